// File: rtl/hazard_controller.sv
// Pipeline hazard control: forwarding selects, load-use/branch/memory stall and flush, data-memory wait FSM.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic [1:0] ResultSrcE,
   input  logic       PCSrcE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MemWait,
   output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCount,
   output logic [31:0] MemWaitCycles
`endif
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned FWD_W  = 2;
   localparam int unsigned PERF_W = 32;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
   localparam logic [FWD_W-1:0] FWD_W_RES = 2'b01;
   localparam logic [FWD_W-1:0] FWD_M_ALU = 2'b10;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic             mem_stall_c;
   logic             lw_stall_c;

   // Operand source select; the younger M-stage result takes precedence over W.
   function automatic logic [FWD_W-1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input logic             wr_m,
      input logic [REG_W-1:0] rd_m,
      input logic             wr_w,
      input logic [REG_W-1:0] rd_w
   );
      logic [FWD_W-1:0] sel;
      sel = FWD_RF;
      if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_M_ALU;
      end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_W_RES;
      end
      return sel;
   endfunction

   assign mem_stall_c = MemReqM && !MemReadyM;
   assign lw_stall_c  = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (mem_stall_c) state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (MemReadyM || !MemReqM) state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   // Memory stall overrides load-use and branch; the branch stays in E until the stall releases.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      MemWait   = (state_q == ST_MEM_WAIT);
      if (mem_stall_c) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall_c;
         StallD = lw_stall_c;
         FlushD = PCSrcE;
         FlushE = lw_stall_c || PCSrcE;
      end
   end

   // Wait counter saturates at the timeout; the timeout flag is sticky until reset.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      if (state_q == ST_RUN) begin
         wait_cnt_d = '0;
      end else if (mem_stall_c && (wait_cnt_q != TIMEOUT_VAL)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_MEM_WAIT) && (wait_cnt_d == TIMEOUT_VAL)) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [PERF_W-1:0] flush_count_q, flush_count_d;
   logic [PERF_W-1:0] mem_wait_cycles_q, mem_wait_cycles_d;

   always_comb begin
      stall_cycles_d    = stall_cycles_q + PERF_W'(StallF);
      flush_count_d     = flush_count_q + PERF_W'(FlushE);
      mem_wait_cycles_d = mem_wait_cycles_q + PERF_W'(mem_stall_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q    <= '0;
         flush_count_q     <= '0;
         mem_wait_cycles_q <= '0;
      end else begin
         stall_cycles_q    <= stall_cycles_d;
         flush_count_q     <= flush_count_d;
         mem_wait_cycles_q <= mem_wait_cycles_d;
      end
   end

   assign StallCycles   = stall_cycles_q;
   assign FlushCount    = flush_count_q;
   assign MemWaitCycles = mem_wait_cycles_q;
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Control-side counterpart of the decode/execute pipeline register in the 5-stage RISC-V core.
- Generates the stall, flush (CLR) and forwarding controls that the pipeline registers and execute-stage muxes consume.
- Adds a sequential wait FSM for a multi-cycle data memory with a req/ready handshake, plus a sticky timeout flag.
- FlushE drives the DE register CLR input; FlushD drives the FD register clear.

Parameters:
- TIMEOUT_CYCLES, 64, MEM_WAIT cycles before MemTimeout sets.
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers.
- RdM, RdW  in  5  memory- and writeback-stage destination registers.
- RegWriteM, RegWriteW  in  1  register-write enables, M and W stages.
- ResultSrcE  in  2  result select, E stage; 2'b01 = load.
- PCSrcE  in  1  branch or jump taken, resolved in E.
- MemReqM  in  1  load or store active in M.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold stage registers.
- FlushD, FlushE, FlushW  out  1  clear stage registers (insert bubble).
- ForwardAE, ForwardBE  out  2  operand select: 00 = regfile, 01 = W result, 10 = M ALU result.
- MemWait  out  1  FSM is in MEM_WAIT.
- MemTimeout  out  1  sticky timeout error.

Behaviour:
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - The M stage wins when M and W both match. ForwardBE is identical with Rs2E.
- Load-use: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = MemReqM && !MemReadyM. This is Mealy and is asserted in the same cycle the request is seen.
- When memStall=1:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0. PCSrcE is ignored; the branch is held in E and re-evaluated after the stall releases.
  - Forwarding is still computed normally.
- When memStall=0:
  - StallE=StallM=FlushW=0.
  - StallF=StallD=lwStall.
  - FlushD=PCSrcE.
  - FlushE=lwStall||PCSrcE.
- FSM states: RUN (reset state) and MEM_WAIT.
  - RUN -> MEM_WAIT on a clock edge where memStall=1.
  - MEM_WAIT -> RUN on a clock edge where MemReadyM=1 or MemReqM=0.
  - MemWait=1 iff the state is MEM_WAIT (registered output).
- Wait counter:
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle in which memStall=1.
  - Saturates at TIMEOUT_CYCLES.
- MemTimeout:
  - Sets on the edge at which the counter reaches TIMEOUT_CYCLES.
  - Clears only on reset.
  - Stalls continue while memStall=1; there is no forced release.
- Reset (rst=0, asynchronous, including mid-wait):
  - State returns to RUN; counter, MemWait and MemTimeout go to 0.
  - Combinational outputs follow the input equations immediately.
  - With all inputs at 0, all outputs are 0.
- Simultaneous events:
  - memStall together with lwStall or PCSrcE: memStall has priority.
  - lwStall together with PCSrcE: FlushD=1, FlushE=1, StallF=StallD=1. The PC hold is overridden by the branch in the fetch logic; this block does not arbitrate that.

Optional Feature:
- HAZARD_PERF_CNT_EN. When defined, adds three outputs:
  - StallCycles (32): counts cycles with StallF=1.
  - FlushCount (32): counts cycles with FlushE=1.
  - MemWaitCycles (32): counts cycles with memStall=1.
- All three counters reset to 0, wrap modulo 2^32, and are captured on the clock edge.
- When undefined, these ports and their logic are absent.

Test Plan:
- RdM=5, RdW=5, RegWriteM=RegWriteW=1, Rs1E=5, Rs2E=5 -> ForwardAE=ForwardBE=10; with RegWriteM=0 -> both 01; with RdM=RdW=0 -> both 00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0; with RdE=0 -> all 0.
- PCSrcE=1, no memory activity -> FlushD=FlushE=1, stalls 0.
- MemReqM=1, MemReadyM low for 3 cycles then high:
  - All four stalls and FlushW=1 for exactly 3 cycles.
  - MemWait=1 on cycles 2-4.
  - State returns to RUN after the ready cycle; MemTimeout stays 0.
- MemReqM=1 with PCSrcE=1 and MemReadyM=0 -> FlushD=FlushE=0 until ready; on the ready cycle FlushD=FlushE=1.
- TIMEOUT_CYCLES=4, MemReadyM held 0 -> MemTimeout=1 after 4 MEM_WAIT cycles and stays 1. Then rst=0 mid-wait -> MemTimeout=0, MemWait=0 immediately, without waiting for a clock edge.
